interrupt_controller: RTL

//  Upstream interrupt source for the pipelined core: collects NUM_SRC external request lines,

---
 rtl/intc_pkg.sv | 19 +
 rtl/intc_sync.sv | 35 +++
 rtl/interrupt_controller.sv | 119 +++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller: FSM state encoding,
// the ID-width helper and the mask reset value.
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } intc_state_e;

  // All sources enabled out of reset; the top slices off NUM_SRC bits.
  localparam logic [15:0] MASK_RST = 16'hFFFF;

  // A single source still needs a 1-bit ID port.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intc_sync.sv
// One interrupt source: SYNC_STAGES-flop synchroniser followed by a registered
// rising-edge detector.
module intc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_q;
  // Fills with ones after reset; edges are ignored until the chain holds real
  // samples, so a line already high through reset is not seen as an event.
  logic [SYNC_STAGES:0]   vld_pipe;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      edge_q   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], async_i};
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      prev_q   <= sync_q[SYNC_STAGES-1];
      edge_q   <= sync_q[SYNC_STAGES-1] & ~prev_q & vld_pipe[SYNC_STAGES];
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/interrupt_controller.sv
// Pending/mask registers, single-winner arbiter and request/handler FSM.
// Define INTC_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter  int NUM_SRC     = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = id_w(NUM_SRC)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               mask_we_i,
  input  logic [NUM_SRC-1:0] mask_wdata_i,
  input  logic               int_taken_i,
  input  logic               int_return_i,
  output logic               interupt_o,
  output logic [ID_W-1:0]    irq_id_o,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               busy_o
);

  logic [NUM_SRC-1:0] edge_w;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] eligible, clr;
  logic [ID_W-1:0]    id_q, id_d, win_id;
  intc_state_e        state_q, state_d;
  int                 start;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    intc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .async_i(irq_src_i[g]),
      .edge_o (edge_w[g])
    );
  end

  assign eligible = pending_q & mask_q;

`ifdef INTC_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr_q, ptr_d;

  assign start = int'(ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == REQ && int_taken_i)
      ptr_d = (id_q == ID_W'(NUM_SRC - 1)) ? '0 : id_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  assign start = 0;
`endif

  // Walk the sources from `start`, wrapping modulo NUM_SRC; first eligible wins.
  always_comb begin
    int  idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    win_id = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = start + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && (((eligible >> idx) & NUM_SRC'(1)) != '0)) begin
        win_id = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    case (state_q)
      IDLE: if (|eligible) begin
        state_d = REQ;
        id_d    = win_id;
      end
      REQ: if (int_taken_i) begin
        state_d = ACTIVE;
        clr     = NUM_SRC'(1) << id_q;
      end
      ACTIVE: if (int_return_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A fresh edge on the source being cleared wins over the clear.
  assign pending_d = (pending_q & ~clr) | edge_w;
  assign mask_d    = mask_we_i ? mask_wdata_i : mask_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      id_q      <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RST[NUM_SRC-1:0];
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  assign interupt_o = (state_q == REQ);
  assign busy_o     = (state_q == ACTIVE);
  assign irq_id_o   = id_q;
  assign pending_o  = pending_q;

endmodule
